regfile_port_ctrl: RTL

Controller that owns the single write port and sequences both read ports of a 2-read/1-write storage array, such as the integer register file. After reset, and on `clear`, it sweeps every entry to zero. It then arbitrates the write port round-robin between two writeback requesters. It forwards same-cycle write data to either read port so that a read/write collision returns the new value. It sits between the pipeline writeback/decode stages and the 2r1w array.

---
 rtl/regfile_port_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/regfile_port_ctrl.sv
`timescale 1ns/1ps
// Write-port owner and read sequencer for a 2r1w array: zero sweep after reset/clear, then round-robin A/B writes.
// Reads take 1 cycle, with same-cycle write forwarding; ready is combinational and held low while sweeping or clearing.
module regfile_port_ctrl #(
  parameter int ELEMENTS_W = 7,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  output logic                  init_done,

  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ELEMENTS_W-1:0] a_address,
  input  logic [WIDTH-1:0]      a_data,

  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [ELEMENTS_W-1:0] b_address,
  input  logic [WIDTH-1:0]      b_data,

  input  logic                  read0,
  input  logic [ELEMENTS_W-1:0] readaddress0,
  output logic [WIDTH-1:0]      readdata0,

  input  logic                  read1,
  input  logic [ELEMENTS_W-1:0] readaddress1,
  output logic [WIDTH-1:0]      readdata1,

  output logic                  mem_read0,
  output logic                  mem_read1,
  output logic [ELEMENTS_W-1:0] mem_readaddress0,
  output logic [ELEMENTS_W-1:0] mem_readaddress1,
  input  logic [WIDTH-1:0]      mem_readdata0,
  input  logic [WIDTH-1:0]      mem_readdata1,

  output logic                  mem_write,
  output logic [ELEMENTS_W-1:0] mem_writeaddress,
  output logic [WIDTH-1:0]      mem_writedata
);

  localparam logic [ELEMENTS_W-1:0] LAST_ADDR = {ELEMENTS_W{1'b1}};

  typedef enum logic {S_INIT, S_RUN} state_t;
  typedef enum logic {GRANT_A, GRANT_B} grant_t;

  typedef struct packed {
    logic                  vld;
    logic [ELEMENTS_W-1:0] addr;
    logic [WIDTH-1:0]      dat;
  } wr_cmd_t;

  state_t                state_q, state_d;
  logic [ELEMENTS_W-1:0] init_cnt_q, init_cnt_d;
  grant_t                last_grant_q, last_grant_d;
  wr_cmd_t               wr;

  logic                  fwd0_q, fwd1_q;
  logic [WIDTH-1:0]      fwd_data0_q, fwd_data1_q;
  logic                  hit0, hit1;

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    last_grant_d = last_grant_q;
    a_ready      = 1'b0;
    b_ready      = 1'b0;
    mem_read0    = 1'b0;
    mem_read1    = 1'b0;
    wr           = '0;

    case (state_q)
      S_INIT: begin
        wr.vld  = 1'b1;
        wr.addr = init_cnt_q;
        wr.dat  = '0;
        if (clear) begin
          init_cnt_d = '0;
        end else if (init_cnt_q == LAST_ADDR) begin
          state_d    = S_RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end

      S_RUN: begin
        mem_read0 = read0;
        mem_read1 = read1;
        if (clear) begin
          // No grant this cycle; the pending requester stays valid and wins after the sweep.
          state_d    = S_INIT;
          init_cnt_d = '0;
        end else if (a_valid && (!b_valid || last_grant_q == GRANT_B)) begin
          a_ready      = 1'b1;
          wr.vld       = 1'b1;
          wr.addr      = a_address;
          wr.dat       = a_data;
          last_grant_d = GRANT_A;
        end else if (b_valid) begin
          b_ready      = 1'b1;
          wr.vld       = 1'b1;
          wr.addr      = b_address;
          wr.dat       = b_data;
          last_grant_d = GRANT_B;
        end
      end

      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // The array is read-old, so a read colliding with this cycle's write must be served from the capture regs.
  assign hit0 = mem_read0 && wr.vld && (readaddress0 == wr.addr);
  assign hit1 = mem_read1 && wr.vld && (readaddress1 == wr.addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_INIT;
      init_cnt_q   <= '0;
      last_grant_q <= GRANT_B;
      fwd0_q       <= 1'b0;
      fwd1_q       <= 1'b0;
      fwd_data0_q  <= '0;
      fwd_data1_q  <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      last_grant_q <= last_grant_d;
      if (mem_read0) begin
        fwd0_q <= hit0;
        if (hit0) fwd_data0_q <= wr.dat;
      end
      if (mem_read1) begin
        fwd1_q <= hit1;
        if (hit1) fwd_data1_q <= wr.dat;
      end
    end
  end

  assign init_done        = (state_q == S_RUN);
  assign mem_readaddress0 = readaddress0;
  assign mem_readaddress1 = readaddress1;
  assign mem_write        = wr.vld;
  assign mem_writeaddress = wr.addr;
  assign mem_writedata    = wr.dat;
  assign readdata0        = fwd0_q ? fwd_data0_q : mem_readdata0;
  assign readdata1        = fwd1_q ? fwd_data1_q : mem_readdata1;

endmodule
